// File: rtl/hub75_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hub75_pkg: shared constants and types for the HUB75 panel-side receiver     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package hub75_pkg;

  localparam int COLS    = 64;
  localparam int COL_W   = 6;
  localparam int ROW_W   = 5;
  localparam int PLANE_W = 2;

  typedef struct packed {
    logic [2:0] rgb0;
    logic [2:0] rgb1;
  } pixel_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DUMP = 1'b1
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/hub75_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hub75_sync_edge: synchronizer, rising-edge detect, post-reset edge blanking |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module hub75_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  localparam int                c_BLANK_W = $clog2(STAGES + 2);
  localparam logic [c_BLANK_W-1:0] c_BLANK = c_BLANK_W'(STAGES + 1);

  logic [STAGES-1:0]    r_sync;
  logic                 r_prev;
  logic [c_BLANK_W-1:0] r_blank;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= {STAGES{RST_VAL}};
      r_prev  <= RST_VAL;
      r_blank <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
      r_prev <= r_sync[STAGES-1];
      if (r_blank != c_BLANK) r_blank <= r_blank + 1'b1;
    end
  end

  // Edges are suppressed until the chain has flushed its reset contents.
  assign q    = r_sync[STAGES-1];
  assign rise = q & ~r_prev & (r_blank == c_BLANK);

endmodule
`default_nettype wire

// File: rtl/hub75_rx_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hub75_rx_capture: rebuilds HUB75 lines and dumps them into a plane RAM      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module hub75_rx_capture
  import hub75_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit LATCH_POL   = 1'b1,
  parameter int OE_W        = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             lp_clk,
  input  logic                             latch,
  input  logic                             noe,
  input  logic [ROW_W-1:0]                 row,
  input  logic [2:0]                       rgb0,
  input  logic [2:0]                       rgb1,
  output logic                             wr_en,
  output logic [PLANE_W+ROW_W+COL_W-1:0]   wr_addr,
  output logic [5:0]                       wr_data,
  output logic                             frame_start,
  output logic                             col_err,
  output logic                             ovr_err,
  input  logic                             clr_err,
  output logic [OE_W-1:0]                  oe_cycles
);

  localparam int                   c_CNT_W    = COL_W + 1;
  localparam int                   c_BUS_W    = ROW_W + 6;
  localparam logic [c_CNT_W-1:0]   c_COLS     = c_CNT_W'(COLS);
  localparam logic [COL_W-1:0]     c_LAST_COL = COL_W'(COLS - 1);

  logic w_lp_q, w_lp_rise, w_lat_q, w_lat_rise, w_noe_q, w_noe_rise, w_unused;

  hub75_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_lp (
    .clk(clk), .rst(rst), .d(lp_clk), .q(w_lp_q), .rise(w_lp_rise)
  );
  hub75_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_lat (
    .clk(clk), .rst(rst), .d(LATCH_POL ? latch : ~latch), .q(w_lat_q), .rise(w_lat_rise)
  );
  hub75_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_noe (
    .clk(clk), .rst(rst), .d(noe), .q(w_noe_q), .rise(w_noe_rise)
  );
  assign w_unused = ^{w_lp_q, w_lat_q, w_noe_rise};

  logic [SYNC_STAGES-1:0][c_BUS_W-1:0] r_bus_sync;
  logic [c_BUS_W-1:0]                  w_bus;
  logic [ROW_W-1:0]                    w_row;
  pixel_t                              w_pix_now, r_pix_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus_sync <= '0;
      r_pix_d    <= '0;
    end else begin
      r_bus_sync <= {r_bus_sync[SYNC_STAGES-2:0], {row, rgb0, rgb1}};
      r_pix_d    <= w_pix_now;
    end
  end

  assign w_bus     = r_bus_sync[SYNC_STAGES-1];
  assign w_row     = w_bus[c_BUS_W-1:6];
  assign w_pix_now = pixel_t'(w_bus[5:0]);

  rx_state_t            r_state, w_state_next;
  pixel_t               r_line [COLS];
  pixel_t               r_hold [COLS];
  logic [c_CNT_W-1:0]   r_shift_cnt, w_cnt_after;
  logic                 r_drop;
  logic [ROW_W-1:0]     r_hold_row, r_last_row;
  logic [PLANE_W-1:0]   r_hold_plane, r_plane, w_plane_next;
  logic                 r_last_row_valid;
  logic [COL_W-1:0]     r_col, w_shift_idx;
  logic [OE_W-1:0]      r_oe_cnt, r_oe_cycles;
  logic                 r_col_err, r_ovr_err;
  logic                 w_drop, w_shift, w_accept, w_reject, w_short;

  assign w_drop       = w_lp_rise && (r_shift_cnt == c_COLS);
  assign w_shift      = w_lp_rise && !w_drop;
  assign w_shift_idx  = r_shift_cnt[COL_W-1:0];
  assign w_cnt_after  = r_shift_cnt + {{COL_W{1'b0}}, w_shift};
  assign w_accept     = w_lat_rise && (r_state == IDLE);
  assign w_reject     = w_lat_rise && (r_state == DUMP);
  // Overflowing shifts saturate the counter, so remember them separately.
  assign w_short      = (w_cnt_after != c_COLS) || r_drop || w_drop;
  assign w_plane_next = (r_last_row_valid && (w_row == r_last_row)) ? r_plane + 1'b1 : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_line <= '{default: '0};
      r_hold <= '{default: '0};
    end else begin
      if (w_shift) r_line[w_shift_idx] <= r_pix_d;
      if (w_accept) begin
        r_hold <= r_line;
        if (w_shift) r_hold[w_shift_idx] <= r_pix_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_shift_cnt      <= '0;
      r_drop           <= 1'b0;
      r_hold_row       <= '0;
      r_hold_plane     <= '0;
      r_last_row       <= '0;
      r_plane          <= '0;
      r_last_row_valid <= 1'b0;
      r_col            <= '0;
      r_oe_cnt         <= '0;
      r_oe_cycles      <= '0;
      r_col_err        <= 1'b0;
      r_ovr_err        <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_col   <= (r_state == DUMP) ? r_col + 1'b1 : '0;

      if (w_lat_rise) begin
        r_shift_cnt <= '0;
        r_drop      <= 1'b0;
        r_oe_cycles <= r_oe_cnt;
        r_oe_cnt    <= '0;
      end else begin
        r_shift_cnt <= w_cnt_after;
        r_drop      <= r_drop | w_drop;
        if (!w_noe_q && (r_oe_cnt != {OE_W{1'b1}})) r_oe_cnt <= r_oe_cnt + 1'b1;
      end

      if (w_accept) begin
        r_hold_row       <= w_row;
        r_hold_plane     <= w_plane_next;
        r_plane          <= w_plane_next;
        r_last_row       <= w_row;
        r_last_row_valid <= 1'b1;
      end

      if (clr_err) begin
        r_col_err <= 1'b0;
        r_ovr_err <= 1'b0;
      end
      if (w_accept && w_short) r_col_err <= 1'b1;
      if (w_reject)            r_ovr_err <= 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    frame_start  = 1'b0;
    case (r_state)
      IDLE: if (w_lat_rise) w_state_next = DUMP;
      DUMP: begin
        wr_en       = 1'b1;
        wr_addr     = {r_hold_plane, r_hold_row, r_col};
        wr_data     = r_hold[r_col];
        frame_start = (r_col == '0) && (r_hold_row == '0) && (r_hold_plane == '0);
        if (r_col == c_LAST_COL) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign col_err   = r_col_err;
  assign ovr_err   = r_ovr_err;
  assign oe_cycles = r_oe_cycles;

endmodule
`default_nettype wire

// File: tb/tb_hub75_rx_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hub75_rx_capture: directed, table-driven bench for hub75_rx_capture      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_hub75_rx_capture;

  logic        clk = 1'b0, rst = 1'b1, lp_clk = 1'b0, latch = 1'b0, noe = 1'b1, clr_err = 1'b0;
  logic [4:0]  row = '0;
  logic [2:0]  rgb0 = '0, rgb1 = '0;
  logic        wr_en, frame_start, col_err, ovr_err;
  logic [12:0] wr_addr;
  logic [5:0]  wr_data;
  logic [15:0] oe_cycles;

  hub75_rx_capture dut (
    .clk(clk), .rst(rst), .lp_clk(lp_clk), .latch(latch), .noe(noe), .row(row),
    .rgb0(rgb0), .rgb1(rgb1), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_start(frame_start), .col_err(col_err), .ovr_err(ovr_err),
    .clr_err(clr_err), .oe_cycles(oe_cycles)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int n_wr = 0, n_fs = 0, n_fs_bad = 0, fs_at = -1;
  logic [12:0] wa [512];
  logic [5:0]  wd [512];
  logic [5:0]  mline [64];
  logic [5:0]  snap [64];
  int          mcnt = 0;

  // Write monitor: records every RAM write in order.
  always @(negedge clk) begin
    if (wr_en) begin
      wa[n_wr % 512] = wr_addr;
      wd[n_wr % 512] = wr_data;
      if (frame_start) begin
        n_fs++;
        fs_at = n_wr;
      end
      n_wr++;
    end else if (frame_start) begin
      n_fs_bad++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic shift_px(input logic [5:0] p);
    rgb0 = p[5:3];
    rgb1 = p[2:0];
    step(2);
    lp_clk = 1'b1;
    step(2);
    lp_clk = 1'b0;
    if (mcnt < 64) begin
      mline[mcnt] = p;
      mcnt++;
    end
  endtask

  task automatic latch_pulse();
    snap  = mline;
    mcnt  = 0;
    latch = 1'b1;
    step(2);
    latch = 1'b0;
    step(1);
  endtask

  task automatic wait_writes(input int base, input string name);
    int k = 0;
    while ((n_wr - base < 64) && (k < 400)) begin
      @(negedge clk);
      #1;
      k++;
    end
    step(4);
    check({name, " write_count"}, n_wr - base, 64);
  endtask

  task automatic check_dump(input int base, input logic [4:0] r, input logic [1:0] pl, input string name);
    int bad_a = 0, bad_d = 0;
    for (int k = 0; k < 64; k++) begin
      logic [5:0] kc;
      kc = 6'(k);
      if (wa[(base + k) % 512] !== {pl, r, kc}) bad_a++;
      if (wd[(base + k) % 512] !== snap[k]) bad_d++;
    end
    check({name, " bad_addr_count"}, bad_a, 0);
    check({name, " bad_data_count"}, bad_d, 0);
  endtask

  typedef struct {
    logic [4:0] row;
    bit         ramp;
    logic [5:0] val;
    logic [1:0] plane;
    int         fs;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int   base, fs0, k;
    logic [5:0] p;

    tbl[0] = '{row: 5'd3, ramp: 1'b1, val: 6'd0,       plane: 2'd0, fs: 0};
    tbl[1] = '{row: 5'd3, ramp: 1'b1, val: 6'd5,       plane: 2'd1, fs: 0};
    tbl[2] = '{row: 5'd3, ramp: 1'b1, val: 6'd9,       plane: 2'd2, fs: 0};
    tbl[3] = '{row: 5'd3, ramp: 1'b1, val: 6'd17,      plane: 2'd3, fs: 0};
    tbl[4] = '{row: 5'd3, ramp: 1'b1, val: 6'd33,      plane: 2'd0, fs: 0};
    tbl[5] = '{row: 5'd4, ramp: 1'b1, val: 6'd1,       plane: 2'd0, fs: 0};
    tbl[6] = '{row: 5'd4, ramp: 1'b1, val: 6'd2,       plane: 2'd1, fs: 0};
    tbl[7] = '{row: 5'd0, ramp: 1'b0, val: 6'b100000,  plane: 2'd0, fs: 1};

    for (int i = 0; i < 64; i++) mline[i] = '0;

    step(4);
    check("reset wr_en", wr_en, 0);
    check("reset wr_addr", wr_addr, 0);
    check("reset wr_data", wr_data, 0);
    check("reset frame_start", frame_start, 0);
    check("reset col_err", col_err, 0);
    check("reset ovr_err", ovr_err, 0);
    check("reset oe_cycles", oe_cycles, 0);
    rst = 1'b0;
    step(5);

    for (int i = 0; i < 8; i++) begin
      row = tbl[i].row;
      for (int c = 0; c < 64; c++) begin
        p = tbl[i].ramp ? 6'(c + int'(tbl[i].val)) : tbl[i].val;
        shift_px(p);
      end
      base = n_wr;
      fs0  = n_fs;
      latch_pulse();
      wait_writes(base, $sformatf("vec%0d", i));
      check_dump(base, tbl[i].row, tbl[i].plane, $sformatf("vec%0d", i));
      check($sformatf("vec%0d frame_start_count", i), n_fs - fs0, tbl[i].fs);
      if (tbl[i].fs != 0) check($sformatf("vec%0d frame_start_pos", i), fs_at, base);
      check($sformatf("vec%0d col_err", i), col_err, 0);
    end

    // Short line: col 63 keeps the previous line's pixel.
    row = 5'd5;
    for (int c = 0; c < 63; c++) shift_px(6'(c) ^ 6'h2A);
    base = n_wr;
    latch_pulse();
    wait_writes(base, "short");
    check_dump(base, 5'd5, 2'd0, "short");
    check("short col63_old", wd[(base + 63) % 512], 6'b100000);
    check("short col_err", col_err, 1);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    check("clr col_err", col_err, 0);

    // Long line: first 64 pixels kept, overflow flagged.
    for (int c = 0; c < 70; c++) shift_px(6'(c * 3));
    base = n_wr;
    latch_pulse();
    wait_writes(base, "long");
    check_dump(base, 5'd5, 2'd1, "long");
    check("long col_err", col_err, 1);

    // Latch during a dump is dropped.
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    check("pre_ovr ovr_err", ovr_err, 0);
    row = 5'd6;
    for (int c = 0; c < 64; c++) shift_px(6'(c + 40));
    base = n_wr;
    latch_pulse();
    step(7);
    mcnt  = 0;
    latch = 1'b1;
    step(2);
    latch = 1'b0;
    wait_writes(base, "ovr");
    step(80);
    check("ovr total_writes", n_wr - base, 64);
    check_dump(base, 5'd6, 2'd0, "ovr");
    check("ovr ovr_err", ovr_err, 1);
    for (int c = 0; c < 64; c++) shift_px(6'(63 - c));
    base = n_wr;
    latch_pulse();
    wait_writes(base, "after_ovr");
    check_dump(base, 5'd6, 2'd1, "after_ovr");

    // NOE on-time between two latches.
    base = n_wr;
    latch_pulse();
    wait_writes(base, "oe_a");
    noe = 1'b0;
    step(37);
    noe = 1'b1;
    step(5);
    base = n_wr;
    latch_pulse();
    wait_writes(base, "oe_b");
    check("oe_cycles", oe_cycles, 37);

    // Reset in the middle of a dump.
    latch = 1'b1;
    step(2);
    latch = 1'b0;
    k = 0;
    while (!(wr_en && wr_addr[5:0] == 6'd20) && (k < 200)) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("rst found write 20", k < 200, 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst wr_en", wr_en, 0);
    check("rst wr_addr", wr_addr, 0);
    check("rst wr_data", wr_data, 0);
    check("rst frame_start", frame_start, 0);
    check("rst col_err", col_err, 0);
    check("rst ovr_err", ovr_err, 0);
    check("rst oe_cycles", oe_cycles, 0);
    step(3);
    rst = 1'b0;
    base = n_wr;
    step(20);
    check("rst no_resume", n_wr - base, 0);
    check("stray frame_start", n_fs_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
